mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing controller between the CPU datapath and the 16×8 data memory. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's level-sensitive `rd`/`wr` strobes with address and data held stable before, during and after each strobe. It returns read data, or a write acknowledge, over a second valid/ready handshake. It also keeps saturating read and write access counters for debug.

## Interface
- `ADDR_W`, 4: memory address width (16 words)
- `DATA_W`, 8: data width
- `CNT_W`, 8: access counter width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  1  CPU request present
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  word address
- `req_wdata`  in  DATA_W  store data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  CPU consumes response
- `rsp_is_write`  out  1  response is a store acknowledge
- `rsp_rdata`  out  DATA_W  load data; unchanged on store acknowledges
- `mem_rd`  out  1  memory read enable
- `mem_wr`  out  1  memory write enable
- `mem_adress`  out  ADDR_W  memory address
- `mem_inDataBus`  out  DATA_W  data to memory
- `mem_outDataBus`  in  DATA_W  data from memory
- `rd_count`, `wr_count`  out  CNT_W  completed loads/stores, saturating

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → RESP → IDLE. All outputs are registered or decoded from state only.
- IDLE: `req_ready`=1. When `req_valid` is high, latch `req_we`, `req_addr` and `req_wdata` into `mem_adress`/`mem_inDataBus`/`we_q`, then go to SETUP.
- SETUP: address and data driven; both strobes low.
- STROBE: exactly one of `mem_rd` (load) or `mem_wr` (store) is high for exactly one cycle.
- HOLD: strobes low, address and data still held. On the exiting edge:
  - load: capture `mem_outDataBus` into `rsp_rdata` and increment `rd_count`;
  - store: increment `wr_count`.
- RESP: `rsp_valid`=1 and `rsp_is_write`=`we_q`. Stays in RESP until `rsp_valid && rsp_ready`, then goes to IDLE.
- `mem_adress` and `mem_inDataBus` change only on acceptance; they hold their last values in IDLE.
- `mem_rd` and `mem_wr` are never high together and never high outside STROBE.
- Counters stop at 2^CNT_W−1 (no wrap).
- Reset (`rst_n`=0 at an edge), from any state including mid-access:
  - state = IDLE, `req_ready`=1;
  - `rsp_valid`, `mem_rd`, `mem_wr` = 0;
  - `mem_adress`, `mem_inDataBus`, `rsp_rdata`, `rsp_is_write`, counters = 0;
  - any in-flight request is dropped with no response.

## Timing
- Acceptance edge E0. SETUP occupies cycle E0–E1, STROBE E1–E2, HOLD E2–E3, and `rsp_valid` rises after E3. Latency from acceptance to response is 4 cycles.
- With `rsp_ready` held high, the response lasts one cycle and the next request is accepted at E5. Peak throughput is 1 access per 5 cycles.
- `req_valid` may be asserted while `req_ready`=0. The request is simply not taken until IDLE, and the requester must hold its fields stable until accepted.
- `rsp_ready` low in RESP stalls indefinitely; `rsp_rdata`/`rsp_is_write` stay stable.
- A request and `rsp_ready` in the same cycle during RESP: only the response completes; the request is taken at the following edge (IDLE).

## Structure
- Shared package `cpu_pkg`: FSM state encoding (3-bit localparams ST_IDLE..ST_RESP) and default ADDR_W/DATA_W.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `count`), instantiated twice for `rd_count` and `wr_count`.

## Test plan
- Memory preloaded with 1..5 at addresses 0..4; load addr 2 with `rsp_ready`=1 → `mem_rd` high for exactly one cycle at E1–E2; `rsp_valid` after E3 with `rsp_rdata`=0x03, `rsp_is_write`=0; `rd_count`=1.
- Store 0xA5 to addr 7, then load addr 7 → store ack with `rsp_is_write`=1 and `rsp_rdata` unchanged; load returns 0xA5; `mem_inDataBus`=0xA5 stable through SETUP/STROBE/HOLD.
- Hold `rsp_ready`=0 for 10 cycles after a load of addr 4 → `rsp_valid` and `rsp_rdata`=0x05 stable all 10 cycles; `req_ready`=0; a new `req_valid` is ignored until after the response handshake.
- Assert `rst_n`=0 during STROBE of a store to addr 9 → next cycle `mem_wr`=0, `req_ready`=1, no response, `wr_count` unchanged.
- Issue 260 back-to-back loads → `rd_count` reaches 255 and stays there; `mem_rd` and `mem_wr` are never both high, checked every cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side memory access path: FSM encoding and default bus widths.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshakes plus the data-memory strobe bus, bundled for one controller.
// slave = controller view; master = CPU + memory view.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_is_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_adress;
    logic [DATA_W-1:0] mem_inDataBus;
    logic [DATA_W-1:0] mem_outDataBus;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_outDataBus,
        output req_ready, rsp_valid, rsp_is_write, rsp_rdata,
        output mem_rd, mem_wr, mem_adress, mem_inDataBus
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_outDataBus,
        input  req_ready, rsp_valid, rsp_is_write, rsp_rdata,
        input  mem_rd, mem_wr, mem_adress, mem_inDataBus
    );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating event counter: +1 per inc pulse, registered, sticks at all-ones.
// Latency 1 cycle; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load/store at a time onto the memory's level rd/wr strobes (SETUP/STROBE/HOLD).
// Response 4 cycles after acceptance; req_ready only in IDLE, RESP stalls while rsp_ready is low.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int CNT_W  = cpu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    state_t            state_q;
    state_t            state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_inc;
    logic              wr_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from state plus the latched direction, so they can never glitch or overlap.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        rd_inc        = 1'b0;
        wr_inc        = 1'b0;
        case (state_q)
            ST_IDLE:   bus.req_ready = 1'b1;
            ST_STROBE: begin
                bus.mem_rd = !we_q;
                bus.mem_wr = we_q;
            end
            ST_HOLD:   begin
                rd_inc = !we_q;
                wr_inc = we_q;
            end
            ST_RESP:   bus.rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Address/data only move on acceptance, so they stay stable around the strobe and through IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && bus.req_valid) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if ((state_q == ST_HOLD) && !we_q) begin
                rdata_q <= bus.mem_outDataBus;
            end
        end
    end

    assign bus.mem_adress    = addr_q;
    assign bus.mem_inDataBus = wdata_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_is_write  = we_q;

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_inc),
        .count (rd_count)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_inc),
        .count (wr_count)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 16x8 behavioural memory on the strobe bus.
module tb_mem_access_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mem_init;
    logic [7:0] rd_count;
    logic [7:0] wr_count;
    logic [7:0] mem [16];
    int         checks;
    int         errors;
    int         cyc;

    mem_access_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous read of the held address; write on any edge while mem_wr is high.
    assign bus.mem_outDataBus = mem[bus.mem_adress];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i < 5) ? 8'(i + 1) : 8'h00;
        end else if (bus.mem_wr) begin
            mem[bus.mem_adress] <= bus.mem_inDataBus;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output logic isw);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            checks++;
            if ((bus.mem_rd & bus.mem_wr) === 1'b1) begin
                errors++;
                $display("FAIL strobe_overlap: mem_rd=%b mem_wr=%b required not both 1", bus.mem_rd, bus.mem_wr);
            end
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, n);
        end
        rd  = bus.rsp_rdata;
        isw = bus.rsp_is_write;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mem_init = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_rd, bus.mem_wr} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/vld/rd/wr=%b required 1000",
                     {bus.req_ready, bus.rsp_valid, bus.mem_rd, bus.mem_wr});
        end
        checks++;
        if ({bus.mem_adress, bus.mem_inDataBus, bus.rsp_rdata, bus.rsp_is_write} !== 21'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h isw=%b required all 0",
                     bus.mem_adress, bus.mem_inDataBus, bus.rsp_rdata, bus.rsp_is_write);
        end
        checks++;
        if (rd_count !== 8'd0 || wr_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: rd=%0d wr=%0d required 0 0", rd_count, wr_count);
        end
        rst_n    = 1'b1;
        mem_init = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd9;
        bus.req_wdata = 8'h3C;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_strobe: mem_wr=%b required 1", bus.mem_wr);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.mem_wr !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_adress !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_after: mem_wr=%b req_ready=%b addr=%h required 0 1 0",
                     bus.mem_wr, bus.req_ready, bus.mem_adress);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || wr_count !== 8'd0) begin
                errors++;
                $display("FAIL rst_mid_norsp: rsp_valid=%b wr_count=%0d required 0 0", bus.rsp_valid, wr_count);
            end
            tick();
        end
    endtask

    task automatic test_load();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd2;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_rd !== 1'b0 || bus.req_ready !== 1'b0 || bus.mem_adress !== 4'd2) begin
            errors++;
            $display("FAIL load_setup: rd=%b rdy=%b addr=%h required 0 0 2", bus.mem_rd, bus.req_ready, bus.mem_adress);
        end
        tick();
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe: rd=%b wr=%b required 1 0", bus.mem_rd, bus.mem_wr);
        end
        tick();
        checks++;
        if (bus.mem_rd !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_hold: rd=%b rsp_valid=%b required 0 0", bus.mem_rd, bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h03 || bus.rsp_is_write !== 1'b0 || rd_count !== 8'd1) begin
            errors++;
            $display("FAIL load_resp: vld=%b rdata=%h isw=%b rd_count=%0d required 1 03 0 1",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_is_write, rd_count);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: vld=%b rdy=%b required 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [7:0] rd;
        logic       isw;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd7;
        bus.req_wdata = 8'hA5;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.req_wdata = 8'h00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.mem_inDataBus !== 8'hA5 || bus.mem_adress !== 4'd7 ||
                bus.mem_wr !== (k == 1) || bus.mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL store_phase%0d: wdata=%h addr=%h wr=%b rd=%b required A5 7 %b 0",
                         k, bus.mem_inDataBus, bus.mem_adress, bus.mem_wr, bus.mem_rd, (k == 1));
            end
            tick();
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_is_write !== 1'b1 || bus.rsp_rdata !== 8'h03 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL store_ack: vld=%b isw=%b rdata=%h wr_count=%0d required 1 1 03 1",
                     bus.rsp_valid, bus.rsp_is_write, bus.rsp_rdata, wr_count);
        end
        tick();
        do_access(1'b0, 4'd7, 8'h00, rd, isw);
        checks++;
        if (rd !== 8'hA5 || isw !== 1'b0 || rd_count !== 8'd2) begin
            errors++;
            $display("FAIL store_readback: rdata=%h isw=%b rd_count=%0d required A5 0 2", rd, isw, rd_count);
        end
    endtask

    task automatic test_stall();
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd4;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.req_valid = 1'b1;
        bus.req_addr  = 4'd0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h05 || bus.req_ready !== 1'b0 || bus.mem_adress !== 4'd4) begin
                errors++;
                $display("FAIL stall_c%0d: vld=%b rdata=%h rdy=%b addr=%h required 1 05 0 4",
                         k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.mem_adress);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_adress !== 4'd4) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b addr=%h required 0 1 4", bus.rsp_valid, bus.req_ready, bus.mem_adress);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_adress !== 4'd0) begin
            errors++;
            $display("FAIL stall_next_accept: rdy=%b addr=%h required 0 0", bus.req_ready, bus.mem_adress);
        end
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h01) begin
            errors++;
            $display("FAIL stall_next_rsp: vld=%b rdata=%h required 1 01", bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
        checks++;
        if (rd_count !== 8'd4) begin
            errors++;
            $display("FAIL stall_rd_count: rd_count=%0d required 4", rd_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic       isw;
        int         start;
        start = cyc;
        for (int i = 0; i < 260; i++) begin
            do_access(1'b0, 4'(i % 5), 8'h00, rd, isw);
            checks++;
            if (rd !== 8'(i % 5 + 1)) begin
                errors++;
                $display("FAIL b2b_data%0d: rdata=%h required %h", i, rd, 8'(i % 5 + 1));
            end
            if (i == 249 || i == 250 || i == 259) begin
                checks++;
                if (rd_count !== ((i == 249) ? 8'd254 : 8'd255)) begin
                    errors++;
                    $display("FAIL b2b_sat%0d: rd_count=%0d required %0d", i, rd_count, (i == 249) ? 254 : 255);
                end
            end
        end
        checks++;
        if (cyc - start != 1300) begin
            errors++;
            $display("FAIL b2b_throughput: cycles=%0d required 1300", cyc - start);
        end
        checks++;
        if (wr_count !== 8'd1) begin
            errors++;
            $display("FAIL b2b_wr_count: wr_count=%0d required 1", wr_count);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_reset_mid_access();
        test_load();
        test_store_load();
        test_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
